// File: rtl/sonic_pkg.sv
// Shared types, default timing constants and the echo-width rule for the
// ultrasonic echo responder.
package sonic_pkg;

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, COOLDOWN} sonic_state_e;

  localparam int CLK_HZ_DEF      = 50_000_000;
  localparam int CLK_PER_US      = CLK_HZ_DEF / 1_000_000;
  localparam int TRIG_MIN_US_DEF = 10;
  localparam int BURST_US_DEF    = 200;
  localparam int US_PER_CM_DEF   = 58;
  localparam int MIN_CM_DEF      = 2;
  localparam int MAX_CM_DEF      = 400;
  localparam int TIMEOUT_US_DEF  = 38000;
  localparam int COOLDOWN_US_DEF = 10000;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Echo width in microseconds: out-of-range distances give the timeout
  // width, near distances are clamped up to the minimum.
  function automatic logic [15:0] echo_width_us(
    input logic [8:0] d,
    input int         us_per_cm,
    input int         min_cm,
    input int         max_cm,
    input int         timeout_us
  );
    int dd;
    int w;
    dd = int'(d);
    if (dd > max_cm) begin
      w = timeout_us;
    end else begin
      if (dd < min_cm) dd = min_cm;
      w = dd * us_per_cm;
    end
    return w[15:0];
  endfunction

endpackage

// File: rtl/sonic_us_timer.sv
// Restartable microsecond timer: a 1 us tick prescaler feeding a 16-bit
// microsecond down-counter. done is high during the last clock cycle of the
// loaded interval, so a state change on done lands exactly load_us*CLK_PER_US
// cycles after start.
module sonic_us_timer #(
  parameter int CLK_PER_US = 50
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] load_us,
  output logic        done
);

  localparam int            TW        = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_PER_US - 1);

  logic [TW-1:0] tick_cnt;
  logic [15:0]   us_cnt;
  logic          tick;

  assign tick = (tick_cnt == TICK_LAST);
  assign done = tick && (us_cnt <= 16'd1);

  // Prescaler and microsecond counter; start realigns both to the new interval.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= '0;
      us_cnt   <= '0;
    end else if (start) begin
      tick_cnt <= '0;
      us_cnt   <= load_us;
    end else if (tick) begin
      tick_cnt <= '0;
      if (us_cnt != 16'd0) us_cnt <= us_cnt - 16'd1;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sonic_echo_responder.sv
// HC-SR04-style sensor emulator: qualifies a trigger pulse, waits out the
// emulated burst, then drives an echo whose width encodes distance_cm.
// Optional range noise: define SONIC_ECHO_JITTER_EN to add a 0..15 us
// LFSR-derived offset to every echo width.
module sonic_echo_responder
  import sonic_pkg::*;
#(
  parameter int CLK_HZ      = CLK_HZ_DEF,
  parameter int TRIG_MIN_US = TRIG_MIN_US_DEF,
  parameter int BURST_US    = BURST_US_DEF,
  parameter int US_PER_CM   = US_PER_CM_DEF,
  parameter int MIN_CM      = MIN_CM_DEF,
  parameter int MAX_CM      = MAX_CM_DEF,
  parameter int TIMEOUT_US  = TIMEOUT_US_DEF,
  parameter int COOLDOWN_US = COOLDOWN_US_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trig,
  input  logic [8:0] distance_cm,
  output logic       echo,
  output logic       busy,
  output logic       trig_err
);

  localparam int CPU = CLK_HZ / 1_000_000;
  // The width counter reads N-1 when the fall is seen after N high cycles.
  localparam logic [15:0] TRIG_MIN_M1 = 16'(TRIG_MIN_US * CPU - 1);

  sonic_state_e state, nxt;
  logic         trig_s1, trig_s2, trig_prev;
  logic         rise, fall;
  logic [15:0]  wcnt;
  logic [15:0]  width_us;
  logic [15:0]  jit;
  logic         t_start, t_done;
  logic [15:0]  t_load;
  logic         accept, reject;

  // Two-flop synchronizer plus edge-detect register for the async trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      trig_s1   <= 1'b0;
      trig_s2   <= 1'b0;
      trig_prev <= 1'b0;
    end else begin
      trig_s1   <= trig;
      trig_s2   <= trig_s1;
      trig_prev <= trig_s2;
    end
  end

  assign rise = trig_s2 & ~trig_prev;
  assign fall = ~trig_s2 & trig_prev;

`ifdef SONIC_ECHO_JITTER_EN
  logic [15:0] lfsr;
  assign jit = {12'd0, lfsr[3:0]};

  // Maximal 16-bit LFSR (taps 16,15,13,4), stepped once per accepted trigger.
  always_ff @(posedge clk) begin
    if (rst)         lfsr <= LFSR_SEED;
    else if (accept) lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[14] ^ lfsr[12] ^ lfsr[3]};
  end
`else
  assign jit = '0;
`endif

  sonic_us_timer #(.CLK_PER_US(CPU)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .start   (t_start),
    .load_us (t_load),
    .done    (t_done)
  );

  // Next-state logic; every timed state entry restarts the shared timer.
  always_comb begin
    nxt     = state;
    t_start = 1'b0;
    t_load  = '0;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE: if (rise) nxt = TRIG_HI;
      TRIG_HI: begin
        if (fall) begin
          if (wcnt >= TRIG_MIN_M1) begin
            nxt     = BURST;
            accept  = 1'b1;
            t_start = 1'b1;
            t_load  = 16'(BURST_US);
          end else begin
            nxt    = IDLE;
            reject = 1'b1;
          end
        end
      end
      BURST: begin
        if (t_done) begin
          nxt     = ECHO;
          t_start = 1'b1;
          t_load  = width_us;
        end
      end
      ECHO: begin
        if (t_done) begin
          nxt     = COOLDOWN;
          t_start = 1'b1;
          t_load  = 16'(COOLDOWN_US);
        end
      end
      COOLDOWN: if (t_done) nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end

  // State, registered outputs, trigger width counter and latched echo width.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      echo     <= 1'b0;
      trig_err <= 1'b0;
      wcnt     <= '0;
      width_us <= '0;
    end else begin
      state    <= nxt;
      echo     <= (nxt == ECHO);
      trig_err <= reject;
      if (state != TRIG_HI)   wcnt <= '0;
      else if (wcnt != '1)    wcnt <= wcnt + 16'd1;
      // Width is resolved at latch time so later distance changes are ignored.
      if (accept) width_us <= echo_width_us(distance_cm, US_PER_CM, MIN_CM, MAX_CM, TIMEOUT_US) + jit;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_sonic_echo_responder.sv
// Self-checking bench for sonic_echo_responder using scaled-down timing.
module tb_sonic_echo_responder;

  localparam int CPU  = 2;
  localparam int TMIN = 10;
  localparam int BUS  = 20;
  localparam int UPC  = 3;
  localparam int MINC = 2;
  localparam int MAXC = 400;
  localparam int TMO  = 1500;
  localparam int CDN  = 50;
  localparam int P    = 10;
  localparam int BUDGET = 20000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trig = 1'b0;
  logic [8:0] distance_cm = '0;
  logic       echo, busy, trig_err;

  int  n_tests = 0, n_fail = 0;
  int  n_rise = 0, n_fall = 0, n_idle = 0, n_err = 0, n_err_cyc = 0;
  time rise_t = 0, fall_t = 0, idle_t = 0;
  logic echo_q = 1'b0, busy_q = 1'b0, err_q = 1'b0;
  logic [15:0] lfsr_m = 16'hACE1;

  always #5 clk = ~clk;

  sonic_echo_responder #(
    .CLK_HZ(CPU * 1_000_000), .TRIG_MIN_US(TMIN), .BURST_US(BUS), .US_PER_CM(UPC),
    .MIN_CM(MINC), .MAX_CM(MAXC), .TIMEOUT_US(TMO), .COOLDOWN_US(CDN)
  ) dut (
    .clk(clk), .rst(rst), .trig(trig), .distance_cm(distance_cm),
    .echo(echo), .busy(busy), .trig_err(trig_err)
  );

  // Event monitor: timestamps of echo edges, busy fall and trig_err pulses.
  always @(negedge clk) begin
    echo_q <= echo;
    busy_q <= busy;
    err_q  <= trig_err;
    if (echo === 1'b1 && echo_q === 1'b0) begin rise_t <= $time; n_rise <= n_rise + 1; end
    if (echo === 1'b0 && echo_q === 1'b1) begin fall_t <= $time; n_fall <= n_fall + 1; end
    if (busy === 1'b0 && busy_q === 1'b1) begin idle_t <= $time; n_idle <= n_idle + 1; end
    if (trig_err === 1'b1 && err_q !== 1'b1) n_err <= n_err + 1;
    if (trig_err === 1'b1) n_err_cyc <= n_err_cyc + 1;
  end

  task automatic check(input string tag, input longint act, input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference echo width in microseconds from the distance rule.
  function automatic int exp_w_us(input int d);
    if (d > MAXC) return TMO;
    return ((d < MINC) ? MINC : d) * UPC;
  endfunction

  task automatic take_jit(output int j);
`ifdef SONIC_ECHO_JITTER_EN
    j = int'(lfsr_m[3:0]);
    lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[14] ^ lfsr_m[12] ^ lfsr_m[3]};
`else
    j = 0;
`endif
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    lfsr_m = 16'hACE1;
  endtask

  task automatic pulse(input int cyc, output time tf);
    @(negedge clk);
    trig = 1'b1;
    repeat (cyc) @(negedge clk);
    trig = 1'b0;
    tf = $time;
  endtask

  task automatic wait_cnt(input string tag, input int which, input int old);
    int k;
    int cur;
    k = 0;
    cur = (which == 0) ? n_rise : (which == 1) ? n_fall : n_idle;
    while (cur == old && k < BUDGET) begin
      @(negedge clk);
      k++;
      cur = (which == 0) ? n_rise : (which == 1) ? n_fall : n_idle;
    end
    check({tag, " wait"}, cur - old, 1);
  endtask

  task automatic txn(input int d, input int cyc, input string tag);
    int r0, e0, ec0, f0, i0, j, wexp;
    time tf;
    r0 = n_rise; e0 = n_err; ec0 = n_err_cyc; f0 = n_fall; i0 = n_idle;
    distance_cm = 9'(d);
    pulse(cyc, tf);
    if (cyc >= TMIN * CPU) begin
      take_jit(j);
      wexp = exp_w_us(d) + j;
      repeat (8) @(negedge clk);
      distance_cm = 9'($urandom);
      wait_cnt(tag, 1, f0);
      check({tag, " delay"}, longint'((rise_t - tf) / P), 3 + BUS * CPU);
      check({tag, " width"}, longint'((fall_t - rise_t) / P), wexp * CPU);
      wait_cnt(tag, 2, i0);
      check({tag, " cooldown"}, longint'((idle_t - fall_t) / P), CDN * CPU);
      check({tag, " echoes"}, n_rise - r0, 1);
      check({tag, " no err"}, n_err - e0, 0);
    end else begin
      repeat (10) @(negedge clk);
      check({tag, " err pulses"}, n_err - e0, 1);
      check({tag, " err cycles"}, n_err_cyc - ec0, 1);
      check({tag, " no echo"}, n_rise - r0, 0);
      check({tag, " idle"}, longint'(busy), 0);
    end
  endtask

  initial begin
    int r0, e0, f0, i0, j, wexp;
    time tf;
    do_reset();
    @(negedge clk);
    check("reset echo", longint'(echo), 0);
    check("reset busy", longint'(busy), 0);
    check("reset trig_err", longint'(trig_err), 0);

    txn(100, 12 * CPU, "d100");
    txn(100, 5 * CPU, "short");
    txn(100, 12 * CPU, "after short");
    txn(50, TMIN * CPU, "min width");
    txn(50, TMIN * CPU - 1, "min width-1");
    txn(401, 12 * CPU, "timeout");
    txn(400, 12 * CPU, "d400");
    txn(0, 12 * CPU, "d0 clamp");
    txn(1, 12 * CPU, "d1 clamp");
    txn(2, 12 * CPU, "d2");

    // Retriggers during ECHO and COOLDOWN plus a trig held high across the
    // return to IDLE: one echo only, width fixed at latch time.
    r0 = n_rise; e0 = n_err; f0 = n_fall; i0 = n_idle;
    distance_cm = 9'd100;
    pulse(12 * CPU, tf);
    take_jit(j);
    wexp = exp_w_us(100) + j;
    wait_cnt("retrig", 0, r0);
    repeat (20) @(negedge clk);
    distance_cm = 9'd7;
    pulse(12 * CPU, tf);
    wait_cnt("retrig", 1, f0);
    check("retrig width", longint'((fall_t - rise_t) / P), wexp * CPU);
    repeat (5) @(negedge clk);
    pulse(12 * CPU, tf);
    repeat (10) @(negedge clk);
    trig = 1'b1;
    wait_cnt("retrig", 2, i0);
    repeat (10) @(negedge clk);
    trig = 1'b0;
    repeat (20) @(negedge clk);
    check("retrig echoes", n_rise - r0, 1);
    check("retrig no err", n_err - e0, 0);
    check("retrig idle", longint'(busy), 0);
    txn(100, 12 * CPU, "post retrig");

    // Reset in the middle of an echo.
    r0 = n_rise;
    distance_cm = 9'd300;
    pulse(12 * CPU, tf);
    take_jit(j);
    wait_cnt("mid rst", 0, r0);
    repeat (1000) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid rst echo", longint'(echo), 0);
    check("mid rst busy", longint'(busy), 0);
    rst = 1'b0;
    lfsr_m = 16'hACE1;
    repeat (5) @(negedge clk);
    txn(300, 12 * CPU, "after rst");

    // Randomized traffic, occasionally with short triggers.
    for (int i = 0; i < 10; i++) begin
      int d, c;
      d = int'($urandom_range(0, 511));
      c = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4, 19)) : int'($urandom_range(20, 60));
      txn(d, c, $sformatf("rand%0d d=%0d c=%0d", i, d, c));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
